// File: rtl/afe_pulser_pkg.sv
// Shared types and helpers for the AFE pulser scheduler.
//   state_e            : scheduler FSM encoding
//   cfg_t              : per-launch configuration (effective period, burst length, width)
//   MIN_PERIOD_DEFAULT : default minimum trigger spacing / manual holdoff in lclk cycles
package afe_pulser_pkg;

  localparam int unsigned PERIOD_W           = 32;
  localparam int unsigned CNT_W              = 16;
  localparam int unsigned WIDTH_W            = 16;
  localparam int unsigned MIN_PERIOD_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  // Configuration captured at launch and held constant while busy
  typedef struct packed {
    logic [PERIOD_W-1:0] eff_period;
    logic [CNT_W-1:0]    n_pulses;
    logic [WIDTH_W-1:0]  width;
  } cfg_t;

  // Raise a requested period to the minimum spacing
  function automatic logic [PERIOD_W-1:0] clamp_period(
    input logic [PERIOD_W-1:0] req,
    input logic [PERIOD_W-1:0] floor_v
  );
    return (req < floor_v) ? floor_v : req;
  endfunction

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/afe_pulser_sched.sv
// Trigger scheduler for the AFE pulser: launches bursts of single-cycle trig
// strobes spaced eff_period apart, or a single manual trig followed by a holdoff.
// Ports:
//   lclk, lclk_rst : clock and synchronous active-high reset
//   start          : rising edge launches a burst (ignored while busy)
//   stop           : rising edge aborts any activity
//   sw_trig        : rising edge in idle requests one manual trig
//   period         : burst trigger spacing in lclk cycles (clamped to MIN_PERIOD)
//   n_pulses       : burst length, 0 = continuous
//   width_in       : pulse width handed to the pulser, latched at launch
//   trig           : single-cycle fire strobe
//   width          : latched pulse width
//   busy           : high whenever the scheduler is not idle
//   pulse_cnt      : burst pulses fired since last launch (saturating)
//   done           : one-cycle strobe on burst completion or abort
module afe_pulser_sched
  import afe_pulser_pkg::*;
#(
  parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
  input  logic                lclk,
  input  logic                lclk_rst,
  input  logic                start,
  input  logic                stop,
  input  logic                sw_trig,
  input  logic [PERIOD_W-1:0] period,
  input  logic [CNT_W-1:0]    n_pulses,
  input  logic [WIDTH_W-1:0]  width_in,
  output logic                trig,
  output logic [WIDTH_W-1:0]  width,
  output logic                busy,
  output logic [CNT_W-1:0]    pulse_cnt,
  output logic                done
);

  localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] HOLD_LOAD = PERIOD_W'(MIN_PERIOD - 2);
  localparam logic [PERIOD_W-1:0] TWO       = PERIOD_W'(2);

  state_e              r_state;
  state_e              w_state_nxt;
  cfg_t                r_cfg;
  cfg_t                w_cfg_nxt;
  logic [PERIOD_W-1:0] r_wait_cnt;
  logic [PERIOD_W-1:0] w_wait_nxt;
  logic [CNT_W-1:0]    r_pulse_cnt;
  logic [CNT_W-1:0]    w_pulse_cnt_nxt;
  logic                r_manual;
  logic                w_manual_nxt;
  logic                r_trig;
  logic                w_trig_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                r_busy;
  logic                w_busy_nxt;

  logic                r_start_d;
  logic                r_stop_d;
  logic                r_sw_d;
  logic                r_armed;
  logic                w_start_e;
  logic                w_stop_e;
  logic                w_sw_e;
  logic                w_burst_end;

  // r_armed masks the first cycle after reset so a level held through
  // release is absorbed into the delay registers instead of reading as an edge.
  assign w_start_e = start   & ~r_start_d & r_armed;
  assign w_stop_e  = stop    & ~r_stop_d  & r_armed;
  assign w_sw_e    = sw_trig & ~r_sw_d    & r_armed;

  assign w_burst_end = (r_cfg.n_pulses != '0) && (r_pulse_cnt == r_cfg.n_pulses);

  // Edge-detect registers
  always_ff @(posedge lclk) begin
    if (lclk_rst) begin
      r_start_d <= 1'b0;
      r_stop_d  <= 1'b0;
      r_sw_d    <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_start_d <= start;
      r_stop_d  <= stop;
      r_sw_d    <= sw_trig;
      r_armed   <= 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge lclk) begin
    if (lclk_rst) begin
      r_state     <= S_IDLE;
      r_cfg       <= '0;
      r_wait_cnt  <= '0;
      r_pulse_cnt <= '0;
      r_manual    <= 1'b0;
      r_trig      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cfg       <= w_cfg_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_pulse_cnt <= w_pulse_cnt_nxt;
      r_manual    <= w_manual_nxt;
      r_trig      <= w_trig_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic. trig/pulse_cnt are computed on the
  // transition into S_FIRE so the registered strobe lines up with S_FIRE.
  always_comb begin
    w_state_nxt     = r_state;
    w_cfg_nxt       = r_cfg;
    w_wait_nxt      = r_wait_cnt;
    w_pulse_cnt_nxt = r_pulse_cnt;
    w_manual_nxt    = r_manual;
    w_trig_nxt      = 1'b0;
    w_done_nxt      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // A stop edge in idle swallows any coincident request
        if (!w_stop_e) begin
          if (w_start_e) begin
            w_cfg_nxt.eff_period = clamp_period(period, MIN_P);
            w_cfg_nxt.n_pulses   = n_pulses;
            w_cfg_nxt.width      = width_in;
            w_manual_nxt         = 1'b0;
            w_pulse_cnt_nxt      = CNT_W'(1);
            w_trig_nxt           = 1'b1;
            w_state_nxt          = S_FIRE;
          end else if (w_sw_e) begin
            w_cfg_nxt.width = width_in;
            w_manual_nxt    = 1'b1;
            w_trig_nxt      = 1'b1;
            w_state_nxt     = S_FIRE;
          end
        end
      end

      S_FIRE: begin
        if (w_stop_e) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_manual) begin
          w_wait_nxt  = HOLD_LOAD;
          w_state_nxt = S_HOLD;
        end else begin
          w_wait_nxt  = r_cfg.eff_period - TWO;
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (w_stop_e) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wait_cnt == '0) begin
          if (w_burst_end) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_pulse_cnt_nxt = sat_inc(r_pulse_cnt);
            w_trig_nxt      = 1'b1;
            w_state_nxt     = S_FIRE;
          end
        end else begin
          w_wait_nxt = r_wait_cnt - PERIOD_W'(1);
        end
      end

      S_HOLD: begin
        if (w_stop_e) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wait_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_wait_nxt = r_wait_cnt - PERIOD_W'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign trig      = r_trig;
  assign width     = r_cfg.width;
  assign busy      = r_busy;
  assign pulse_cnt = r_pulse_cnt;
  assign done      = r_done;

endmodule

// File: doc/afe_pulser_sched.md
AFE_PULSER_SCHED -- requirements
Module: afe_pulser_sched

Interface
REQ-001 SHALL have parameter MIN_PERIOD, default 8, giving the minimum lclk cycles between successive trig pulses and the post-fire holdoff.
REQ-002 SHALL have port lclk  input  1  the single clock for all logic.
REQ-003 SHALL have port lclk_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  level; its rising edge launches a burst.
REQ-005 SHALL have port stop  input  1  level; its rising edge aborts any activity.
REQ-006 SHALL have port sw_trig  input  1  level; its rising edge requests one manual pulse.
REQ-007 SHALL have port period  input  32  lclk cycles between burst triggers.
REQ-008 SHALL have port n_pulses  input  16  burst length; 0 means continuous.
REQ-009 SHALL have port width_in  input  16  pulse width, in fastclk bits, for the pulser.
REQ-010 SHALL have port trig  output  1  single-cycle fire strobe to the pulser trig input.
REQ-011 SHALL have port width  output  16  width presented to the pulser; stable while busy.
REQ-012 SHALL have port busy  output  1  high in every state except S_IDLE.
REQ-013 SHALL have port pulse_cnt  output  16  number of burst pulses fired since the last launch.
REQ-014 SHALL have port done  output  1  one-cycle strobe at burst completion or abort.

Function
REQ-015 SHALL detect rising edges internally as in & ~in_d, registered per input, for start, stop and sw_trig.
REQ-016 SHALL implement states S_IDLE, S_FIRE, S_WAIT and S_HOLD; all outputs are registered.
REQ-017 On a start edge in S_IDLE, SHALL latch eff_period = max(period, MIN_PERIOD), n_pulses and width_in, clear pulse_cnt, and go to S_FIRE.
REQ-018 In S_FIRE, SHALL assert trig for exactly one cycle, increment pulse_cnt (saturating at 16'hFFFF), load the wait counter with eff_period-2, and go to S_WAIT.
REQ-019 In S_WAIT, SHALL decrement the counter. At zero:
  - if n_pulses != 0 and pulse_cnt == n_pulses: pulse done and go to S_IDLE;
  - otherwise go to S_FIRE.
REQ-020 Timing: a start edge sampled at cycle N SHALL give trig k at cycle N+1+(k-1)*eff_period; done and busy deassertion SHALL occur at N+1+n_pulses*eff_period.
REQ-021 On a sw_trig edge in S_IDLE with no start edge, SHALL latch width_in, assert trig in the next cycle, then hold in S_HOLD for MIN_PERIOD-1 cycles before returning to S_IDLE; pulse_cnt SHALL be unchanged and no done strobe issued.
REQ-022 SHALL give a start edge priority over a sw_trig edge in the same cycle; sw_trig SHALL then be dropped.
REQ-023 SHALL ignore start and sw_trig edges while busy.
REQ-024 On a stop edge in any busy state, SHALL go to S_IDLE next cycle, suppress any trig in that cycle, and pulse done.
REQ-025 A stop edge in S_IDLE SHALL have no effect; a simultaneous start or sw_trig edge in that cycle SHALL be dropped.
REQ-026 Continuous mode (n_pulses = 0) SHALL run until stop; pulse_cnt SHALL saturate rather than wrap.
REQ-027 Changes to period, n_pulses or width_in while busy SHALL have no effect until the next launch.

Reset
REQ-028 While lclk_rst is high, SHALL drive fsm = S_IDLE, trig = 0, done = 0, busy = 0, pulse_cnt = 0, width = 0, wait counter = 0, and edge registers = 0.
REQ-029 Reset mid-burst SHALL abort with no trig and no done strobe.
REQ-030 An input held high through reset release SHALL NOT produce an edge.

Structure
REQ-031 SHALL place the state encoding and the default MIN_PERIOD in shared package afe_pulser_pkg.
REQ-032 SHALL need no sub-module; trig and width connect directly to the afe_pulser trig and width inputs.

Verification
REQ-033 Burst: start with period=20, n_pulses=3, width_in=13 -> trig at N+1, N+21, N+41; done at N+61; pulse_cnt=3; width=13 throughout.
REQ-034 Clamp: start with period=2, n_pulses=2 -> trigs 8 cycles apart; done 16 cycles after the first trig.
REQ-035 Manual: sw_trig edge in idle -> one trig; busy for 8 cycles; pulse_cnt unchanged; no done.
REQ-036 Abort: continuous, period=10; stop edge 3 cycles after the 4th trig -> no further trig; done 1 cycle later; pulse_cnt=4.
REQ-037 Collision: start and sw_trig edges in the same cycle, then start again while busy -> a single burst runs; the extra requests are ignored.
REQ-038 Reset mid-S_WAIT -> all outputs 0 next cycle; with start held high through release, no trig.
